mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_tag_table.sv | 37 +++
 rtl/mem_arbiter.sv | 87 ++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared bus encodings, owner enum and widths for the memory arbiter.
package mem_arbiter_pkg;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int TAG_W    = 4;
    localparam int NUM_TAGS = 15;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;
endpackage

// File: rtl/mem_tag_table.sv
// mem_tag_table: records which port owns each outstanding load tag (tags 1..15).
module mem_tag_table
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_en,
    input  logic [TAG_W-1:0] alloc_tag,
    input  owner_e           alloc_owner,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic             retire,
    output logic             lookup_valid,
    output owner_e           lookup_owner,
    output logic             collision
);
    // Slot 0 exists only so any 4-bit tag can index directly; it is never set.
    logic [NUM_TAGS:0] valid;
    logic [NUM_TAGS:0] owner_q;
    logic [NUM_TAGS:0] set_m;
    logic [NUM_TAGS:0] clr_m;
    logic              alloc_hit;
    always_comb begin
        alloc_hit    = alloc_en && alloc_tag != '0;
        lookup_valid = lookup_tag != '0 && valid[lookup_tag];
        lookup_owner = owner_e'(owner_q[lookup_tag]);
        collision    = alloc_hit && valid[alloc_tag] && !(retire && lookup_valid && lookup_tag == alloc_tag);
        set_m        = alloc_hit ? {{NUM_TAGS{1'b0}}, 1'b1} << alloc_tag : '0;
        clr_m        = retire && lookup_valid ? {{NUM_TAGS{1'b0}}, 1'b1} << lookup_tag : '0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid <= '0;
        else      valid <= (valid & ~clr_m) | set_m;
    end
    always_ff @(posedge clk) begin
        if (alloc_hit) owner_q[alloc_tag] <= alloc_owner;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between instruction and data ports, data first
// with starvation relief for the instruction port, and routes tagged load returns.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        if2arb_command,
    input  logic [ADDR_W-1:0] if2arb_addr,
    output logic [TAG_W-1:0]  arb2if_response,
    output logic [DATA_W-1:0] arb2if_data,
    output logic [TAG_W-1:0]  arb2if_tag,
    input  logic [1:0]        dm2arb_command,
    input  logic [ADDR_W-1:0] dm2arb_addr,
    input  logic [DATA_W-1:0] dm2arb_data,
    output logic [TAG_W-1:0]  arb2dm_response,
    output logic [DATA_W-1:0] arb2dm_data,
    output logic [TAG_W-1:0]  arb2dm_tag,
    output logic [1:0]        arb2mem_command,
    output logic [ADDR_W-1:0] arb2mem_addr,
    output logic [DATA_W-1:0] arb2mem_data,
    input  logic [TAG_W-1:0]  mem2arb_response,
    input  logic [DATA_W-1:0] mem2arb_data,
    input  logic [TAG_W-1:0]  mem2arb_tag,
    output logic              arb_err
);
    localparam int CW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
    logic [CW-1:0] starve;
    logic          if_req;
    logic          dm_req;
    logic          force_if;
    logic          grant_if;
    logic          grant_dm;
    logic          accepted;
    logic          alloc_en;
    logic          lookup_valid;
    logic          ret_valid;
    logic          bad_ret;
    logic          collision;
    owner_e        ret_owner;
    // Grants are qualified by reset so nothing reaches memory while rst is low.
    always_comb begin
        if_req          = if2arb_command != BUS_NONE;
        dm_req          = dm2arb_command != BUS_NONE;
        force_if        = starve == CW'(STARVE_LIMIT);
        grant_if        = rst && if_req && (!dm_req || force_if);
        grant_dm        = rst && dm_req && !grant_if;
        accepted        = mem2arb_response != '0;
        arb2mem_command = grant_dm ? dm2arb_command : grant_if ? if2arb_command : BUS_NONE;
        arb2mem_addr    = grant_dm ? dm2arb_addr : grant_if ? if2arb_addr : '0;
        arb2mem_data    = grant_dm ? dm2arb_data : '0;
        arb2if_response = grant_if ? mem2arb_response : '0;
        arb2dm_response = grant_dm ? mem2arb_response : '0;
        alloc_en        = accepted && arb2mem_command == BUS_LOAD;
    end
    always_comb begin
        ret_valid   = rst && lookup_valid;
        bad_ret     = rst && mem2arb_tag != '0 && !lookup_valid;
        arb2if_tag  = ret_valid && ret_owner == OWN_IF ? mem2arb_tag : '0;
        arb2if_data = ret_valid && ret_owner == OWN_IF ? mem2arb_data : '0;
        arb2dm_tag  = ret_valid && ret_owner == OWN_DM ? mem2arb_tag : '0;
        arb2dm_data = ret_valid && ret_owner == OWN_DM ? mem2arb_data : '0;
    end
    mem_tag_table u_tag_table (
        .clk         (clk),
        .rst         (rst),
        .alloc_en    (alloc_en),
        .alloc_tag   (mem2arb_response),
        .alloc_owner (owner_e'(grant_dm)),
        .lookup_tag  (mem2arb_tag),
        .retire      (ret_valid),
        .lookup_valid(lookup_valid),
        .lookup_owner(ret_owner),
        .collision   (collision)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve  <= '0;
            arb_err <= 1'b0;
        end else begin
            starve  <= grant_if && accepted ? '0 : if_req && !force_if ? starve + 1'b1 : starve;
            arb_err <= arb_err | bad_ret | collision;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random traffic against a tag-ownership reference model,
// expected outputs queued per cycle and checked by an independent monitor.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;
    localparam int LIMIT = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  if2arb_command = '0;
    logic [31:0] if2arb_addr = '0;
    logic [3:0]  arb2if_response;
    logic [31:0] arb2if_data;
    logic [3:0]  arb2if_tag;
    logic [1:0]  dm2arb_command = '0;
    logic [31:0] dm2arb_addr = '0;
    logic [31:0] dm2arb_data = '0;
    logic [3:0]  arb2dm_response;
    logic [31:0] arb2dm_data;
    logic [3:0]  arb2dm_tag;
    logic [1:0]  arb2mem_command;
    logic [31:0] arb2mem_addr;
    logic [31:0] arb2mem_data;
    logic [3:0]  mem2arb_response = '0;
    logic [31:0] mem2arb_data = '0;
    logic [3:0]  mem2arb_tag = '0;
    logic        arb_err;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if2arb_command(if2arb_command), .if2arb_addr(if2arb_addr),
        .arb2if_response(arb2if_response), .arb2if_data(arb2if_data), .arb2if_tag(arb2if_tag),
        .dm2arb_command(dm2arb_command), .dm2arb_addr(dm2arb_addr), .dm2arb_data(dm2arb_data),
        .arb2dm_response(arb2dm_response), .arb2dm_data(arb2dm_data), .arb2dm_tag(arb2dm_tag),
        .arb2mem_command(arb2mem_command), .arb2mem_addr(arb2mem_addr), .arb2mem_data(arb2mem_data),
        .mem2arb_response(mem2arb_response), .mem2arb_data(mem2arb_data), .mem2arb_tag(mem2arb_tag),
        .arb_err(arb_err)
    );

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  if_resp;
        logic [3:0]  if_tag;
        logic [31:0] if_data;
        logic [3:0]  dm_resp;
        logic [3:0]  dm_tag;
        logic [31:0] dm_data;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;
    // Reference state: owner per tag (-1 none, 0 instruction, 1 data), denial count, sticky error.
    int   own[16];
    int   starve;
    bit   err_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("arb2mem_command", 32'(arb2mem_command), 32'(me.cmd));
            chk("arb2mem_addr", arb2mem_addr, me.addr);
            chk("arb2mem_data", arb2mem_data, me.data);
            chk("arb2if_response", 32'(arb2if_response), 32'(me.if_resp));
            chk("arb2if_tag", 32'(arb2if_tag), 32'(me.if_tag));
            chk("arb2if_data", arb2if_data, me.if_data);
            chk("arb2dm_response", 32'(arb2dm_response), 32'(me.dm_resp));
            chk("arb2dm_tag", 32'(arb2dm_tag), 32'(me.dm_tag));
            chk("arb2dm_data", arb2dm_data, me.dm_data);
            chk("arb_err", 32'(arb_err), 32'(me.err));
        end
    end

    task automatic cyc(input logic [1:0] ic, input logic [31:0] ia, input logic [1:0] dc,
                       input logic [31:0] da, input logic [31:0] dd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [31:0] rd, input logic rv);
        exp_t e;
        bit   ifr, dmr, ifw, dmw, hit;
        @(posedge clk);
        #1;
        if2arb_command = ic; if2arb_addr = ia;
        dm2arb_command = dc; dm2arb_addr = da; dm2arb_data = dd;
        mem2arb_response = rs; mem2arb_tag = rt; mem2arb_data = rd;
        rst = rv;
        e = '{default: '0};
        if (!rv) begin
            foreach (own[i]) own[i] = -1;
            starve = 0;
            err_m  = 0;
            q.push_back(e);
            return;
        end
        ifr = ic != 2'd0;
        dmr = dc != 2'd0;
        ifw = ifr && (!dmr || starve == LIMIT);
        dmw = dmr && !ifw;
        e.cmd     = ifw ? ic : dmw ? dc : 2'd0;
        e.addr    = ifw ? ia : dmw ? da : 32'd0;
        e.data    = dmw ? dd : 32'd0;
        e.if_resp = ifw ? rs : 4'd0;
        e.dm_resp = dmw ? rs : 4'd0;
        hit = rt != 0 && own[rt] >= 0;
        if (hit && own[rt] == 0) begin e.if_tag = rt; e.if_data = rd; end
        if (hit && own[rt] == 1) begin e.dm_tag = rt; e.dm_data = rd; end
        e.err = err_m;
        q.push_back(e);
        if (ifr) starve = (ifw && rs != 0) ? 0 : (starve < LIMIT ? starve + 1 : starve);
        if (rt != 0 && !hit) err_m = 1;
        if (hit) own[rt] = -1;
        if (rs != 0 && ((ifw && ic == BUS_LOAD) || (dmw && dc == BUS_LOAD))) begin
            if (own[rs] >= 0) err_m = 1;
            own[rs] = dmw ? 1 : 0;
        end
    endtask

    task automatic idle(input logic rv);
        cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd0, 0, rv);
    endtask

    task automatic rand_cyc(input logic rv);
        logic [3:0] rs, rt;
        rs = 4'($urandom_range(1, 15));
        for (int k = 0; k < 4 && own[rs] >= 0; k++) rs = 4'($urandom_range(1, 15));
        if ($urandom_range(0, 3) == 0) rs = 4'd0;
        rt = 4'd0;
        if ($urandom_range(0, 1) == 0)
            for (int k = 0; k < 8 && rt == 0; k++) begin
                rt = 4'($urandom_range(1, 15));
                if (own[rt] < 0) rt = 4'd0;
            end
        if ($urandom_range(0, 40) == 0) rt = 4'($urandom_range(1, 15));
        cyc(2'($urandom_range(0, 2)), $urandom, 2'($urandom_range(0, 2)), $urandom, $urandom,
            rs, rt, $urandom, rv);
    endtask

    initial begin
        foreach (own[i]) own[i] = -1;
        starve = 0;
        err_m  = 0;
        // Traffic and returns while in reset are ignored and raise no error.
        cyc(BUS_LOAD, 32'h40, BUS_LOAD, 32'h80, 0, 4'd3, 4'd3, 32'h1234, 1'b0);
        cyc(BUS_STORE, 32'h44, BUS_NONE, 0, 0, 4'd9, 4'd7, 32'h1, 1'b0);
        // Data wins a simultaneous request; the load return goes to the data port.
        cyc(BUS_LOAD, 32'h0, BUS_LOAD, 32'h100, 0, 4'd3, 4'd0, 0, 1'b1);
        idle(1'b1);
        cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd3, 32'hDEADBEEF, 1'b1);
        // Starvation relief from a cleared counter: instruction port wins the fifth cycle.
        idle(1'b0);
        for (int i = 0; i < 6; i++)
            cyc(BUS_LOAD, 32'h200 + 32'(i * 4), BUS_STORE, 32'h300, 32'(i), 4'd1, 4'd0, 0, 1'b1);
        cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd1, 32'hAAAA5555, 1'b1);
        // Tag 5 retired to IF and reallocated to DM in the same cycle.
        cyc(BUS_LOAD, 32'h500, BUS_NONE, 0, 0, 4'd5, 4'd0, 0, 1'b1);
        cyc(BUS_NONE, 0, BUS_LOAD, 32'h600, 0, 4'd5, 4'd5, 32'h55555555, 1'b1);
        cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd5, 32'h66666666, 1'b1);
        // Reset mid-stream drops outstanding tags.
        cyc(BUS_LOAD, 32'h10, BUS_NONE, 0, 0, 4'd6, 4'd0, 0, 1'b1);
        cyc(BUS_NONE, 0, BUS_LOAD, 32'h20, 0, 4'd7, 4'd0, 0, 1'b1);
        cyc(BUS_LOAD, 32'h30, BUS_LOAD, 32'h34, 0, 4'd8, 4'd6, 32'h77, 1'b0);
        cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd6, 32'h88, 1'b1);
        cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd7, 32'h99, 1'b1);
        // A store allocates nothing, so its tag coming back is an error.
        idle(1'b0);
        cyc(BUS_NONE, 0, BUS_STORE, 32'h30, 32'hABC, 4'd2, 4'd0, 0, 1'b1);
        cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd2, 32'h22, 1'b1);
        idle(1'b1);
        // Stray return with nothing outstanding; error must hold through traffic.
        idle(1'b0);
        cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd7, 32'h70, 1'b1);
        for (int i = 0; i < 8; i++) rand_cyc(1'b1);
        // Collision: allocate onto an outstanding tag.
        idle(1'b0);
        cyc(BUS_LOAD, 32'h900, BUS_NONE, 0, 0, 4'd4, 4'd0, 0, 1'b1);
        cyc(BUS_NONE, 0, BUS_LOAD, 32'h904, 0, 4'd4, 4'd0, 0, 1'b1);
        cyc(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd4, 32'h44, 1'b1);
        for (int b = 0; b < 4; b++) begin
            idle(1'b0);
            for (int i = 0; i < 150; i++) rand_cyc(1'b1);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
